// File: rtl/cache_dualport_be_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the dual-port byte-enable cache RAM:
//   - controller state encoding (ST_IDLE, ST_CLEAR)
//   - MAX_READ_LATENCY, the deepest supported output pipeline
//   - calc_nbe(), the number of byte-enable lanes per word
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_CLEAR = 1'b1;

    localparam int MAX_READ_LATENCY = 2;

    function automatic int calc_nbe(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/cache_dualport_be_if.sv
// -----------------------------------------------------------------------------
// cache_dualport_be_if
// Bus bundle for cache_dualport_be: port A (read/write), port B (read-only),
// flush request and the shared ready flag.
//   master : requester side (drives i_*, receives o_*)
//   slave  : cache RAM side (receives i_*, drives o_*)
// -----------------------------------------------------------------------------
interface cache_dualport_be_if
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8
);
    localparam int NBE = calc_nbe(DATA_WIDTH, BYTE_WIDTH);

    logic                  i_request;
    logic                  i_write;
    logic [NBE-1:0]        i_byteen;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_DV;
    logic                  i_request_b;
    logic [ADDR_WIDTH-1:0] i_address_b;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic                  o_data_b_DV;
    logic                  i_flush;
    logic                  o_ready;

    modport master (
        output i_request, i_write, i_byteen, i_address, i_data,
        output i_request_b, i_address_b, i_flush,
        input  o_data, o_data_DV, o_data_b, o_data_b_DV, o_ready
    );

    modport slave (
        input  i_request, i_write, i_byteen, i_address, i_data,
        input  i_request_b, i_address_b, i_flush,
        output o_data, o_data_DV, o_data_b, o_data_b_DV, o_ready
    );

endinterface

// File: rtl/cache_dualport_be_ram_core.sv
// -----------------------------------------------------------------------------
// cache_ram_core
// Inferred true-dual-port array, no reset on storage or outputs.
//   i_clk          clock, rising edge
//   we_a, be_a     port A write enable and per-lane byte enables
//   addr_a, wdata_a port A address / write data
//   rdata_a        port A registered read data (write-first: merged new word)
//   addr_b         port B read address
//   rdata_b        port B registered read data (old word on collision)
// -----------------------------------------------------------------------------
module cache_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8,
    parameter int NBE        = 4
) (
    input  logic                  i_clk,
    input  logic                  we_a,
    input  logic [NBE-1:0]        be_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Lanes being written bypass onto rdata_a; untouched lanes show stored data.
    // Port B reads mem with a non-blocking update pending, so it sees the old word.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NBE; k++) begin
            if (we_a && be_a[k]) begin
                mem[addr_a][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a[k*BYTE_WIDTH +: BYTE_WIDTH];
                rdata_a[k*BYTE_WIDTH +: BYTE_WIDTH]     <= wdata_a[k*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                rdata_a[k*BYTE_WIDTH +: BYTE_WIDTH]     <= mem[addr_a][k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/cache_dualport_be.sv
// -----------------------------------------------------------------------------
// cache_dualport_be
// Dual-port cache RAM with byte-enable writes, 1- or 2-cycle read latency,
// read-only handshaked port B and a clear engine that sweeps CLEAR_VALUE
// through every word after reset (optional) or on a flush request.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (control only; memory untouched)
//   bus      cache_dualport_be_if.slave: port A, port B, flush, ready
// -----------------------------------------------------------------------------
module cache_dualport_be
    import cache_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   ADDR_WIDTH     = 12,
    parameter int                   BYTE_WIDTH     = 8,
    parameter int                   READ_LATENCY   = 1,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    cache_dualport_be_if.slave bus
);
    localparam int     NBE         = calc_nbe(DATA_WIDTH, BYTE_WIDTH);
    localparam bit     LAT2        = (READ_LATENCY == MAX_READ_LATENCY);
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                state, state_nxt;
    logic                  ready, clearing;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  acc_a_p0, acc_b_p0, we_p0;
    logic [NBE-1:0]        be_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    logic [DATA_WIDTH-1:0] rdata_a_p1, rdata_b_p1;
    logic                  vld_a_p1, vld_b_p1;
    logic [DATA_WIDTH-1:0] data_a_p2, data_b_p2;
    logic                  vld_a_p2, vld_b_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RESET_STATE;
        else          state <= state_nxt;
    end

    // A flush is only honoured in IDLE, so a sweep never restarts itself.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.i_flush)      state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == '1)    state_nxt = ST_IDLE;
            default:                        state_nxt = RESET_STATE;
        endcase
    end

    always_comb begin
        ready    = (state == ST_IDLE);
        clearing = (state == ST_CLEAR);
    end

    // Wraps all-ones -> 0 on the same edge the FSM returns to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      clr_cnt <= '0;
        else if (clearing) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end

    // ---- p0: request acceptance and write-port mux (clear engine owns port A in CLEAR)
    assign acc_a_p0 = bus.i_request   & ready;
    assign acc_b_p0 = bus.i_request_b & ready;
    assign we_p0    = clearing | (acc_a_p0 & bus.i_write);
    assign be_p0    = clearing ? {NBE{1'b1}} : bus.i_byteen;
    assign addr_p0  = clearing ? clr_cnt     : bus.i_address;
    assign wdata_p0 = clearing ? CLEAR_VALUE : bus.i_data;

    cache_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NBE        (NBE)
    ) u_core (
        .i_clk   (i_clk),
        .we_a    (we_p0),
        .be_a    (be_p0),
        .addr_a  (addr_p0),
        .wdata_a (wdata_p0),
        .rdata_a (rdata_a_p1),
        .addr_b  (bus.i_address_b),
        .rdata_b (rdata_b_p1)
    );

    // ---- p1 -> p2: valid shift registers (control, reset) and optional data stage (no reset)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
            vld_a_p2 <= 1'b0;
            vld_b_p2 <= 1'b0;
        end else begin
            vld_a_p1 <= acc_a_p0;
            vld_b_p1 <= acc_b_p0;
            vld_a_p2 <= vld_a_p1;
            vld_b_p2 <= vld_b_p1;
        end
    end

    always_ff @(posedge i_clk) begin
        data_a_p2 <= rdata_a_p1;
        data_b_p2 <= rdata_b_p1;
    end

    assign bus.o_data      = LAT2 ? data_a_p2 : rdata_a_p1;
    assign bus.o_data_DV   = LAT2 ? vld_a_p2  : vld_a_p1;
    assign bus.o_data_b    = LAT2 ? data_b_p2 : rdata_b_p1;
    assign bus.o_data_b_DV = LAT2 ? vld_b_p2  : vld_b_p1;
    assign bus.o_ready     = ready;

endmodule
